// File: rtl/dest_track_pipe_pkg.sv
// Shared types for the destination-tracking pipe (EX/MEM -> MEM/WB).
// Provides word/register/opcode types, the FSM state enum, the stage
// payload struct and the BUBBLE constant used on flush.
package dest_track_pipe_pkg;

  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned REG_BITS  = 5;
  localparam int unsigned OP_BITS   = 6;

  typedef logic [WORD_BITS-1:0] word_t;
  typedef logic [REG_BITS-1:0]  regbits_t;

  typedef enum logic [OP_BITS-1:0] {
    RTYPE = 6'h00,
    ADDIU = 6'h09,
    LW    = 6'h23,
    SW    = 6'h2B
  } opcode_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dtrack_state_t;

  typedef struct packed {
    regbits_t rd;
    logic     regW;
    opcode_t  op;
    logic     dREN;
    logic     dWEN;
    word_t    data;
    word_t    store;
  } stage_t;

  localparam stage_t BUBBLE = '{
    rd:    '0,
    regW:  1'b0,
    op:    RTYPE,
    dREN:  1'b0,
    dWEN:  1'b0,
    data:  '0,
    store: '0
  };

endpackage

// File: rtl/dest_stage_reg.sv
// One pipeline stage register carrying a stage_t payload.
// Ports: CLK, nRST (sync, active-low), en (advance), bubble (load BUBBLE
// instead of d), zero_rd_supp (force regW=0 when rd==0), d / q payload.
module dest_stage_reg
  import dest_track_pipe_pkg::*;
(
  input  logic   CLK,
  input  logic   nRST,
  input  logic   en,
  input  logic   bubble,
  input  logic   zero_rd_supp,
  input  stage_t d,
  output stage_t q
);

  stage_t d_eff;

  // $zero must never look like a forwarding source
  always_comb begin
    d_eff = d;
    if (bubble) begin
      d_eff = BUBBLE;
    end else if (zero_rd_supp && (d.rd == '0)) begin
      d_eff.regW = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      q <= '0;
    end else if (en) begin
      q <= d_eff;
    end
  end

endmodule

// File: rtl/dest_track_pipe.sv
// EX/MEM and MEM/WB destination tracking for the forwarding unit, plus the
// EX/MEM data-memory handshake (dREN/dWEN vs dhit).
// Ports: CLK, nRST (sync active-low), ihit/dhit/flush control, idex_* inputs
// from ID/EX, dmem_rdata; outputs dREN/dWEN/daddr/dstore to data memory,
// exmem_* / memwb_* to the forwarding unit and register file, mem_stall.
// Optional: DEST_TRACK_STALL_CNT_EN adds stall_cycles (saturating count of
// mem_stall cycles).
module dest_track_pipe
  import dest_track_pipe_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              flush,
  input  logic [REG_W-1:0]  idex_rd,
  input  logic              idex_regW,
  input  logic [5:0]        idex_op,
  input  logic              idex_dREN,
  input  logic              idex_dWEN,
  input  logic [WORD_W-1:0] idex_result,
  input  logic [WORD_W-1:0] idex_store,
  input  logic [WORD_W-1:0] dmem_rdata,
  output logic              dREN,
  output logic              dWEN,
  output logic [WORD_W-1:0] daddr,
  output logic [WORD_W-1:0] dstore,
  output logic [REG_W-1:0]  exmem_rd,
  output logic              exmem_regW,
  output logic [5:0]        exmem_op,
  output logic [WORD_W-1:0] exmem_data,
  output logic [REG_W-1:0]  memwb_rd,
  output logic              memwb_regW,
  output logic [5:0]        memwb_op,
  output logic [WORD_W-1:0] memwb_wdata,
`ifdef DEST_TRACK_STALL_CNT_EN
  output logic [31:0]       stall_cycles,
`endif
  output logic              mem_stall
);

  dtrack_state_t state, state_n;
  stage_t        idex_s, exmem_q, memwb_d, memwb_q;
  word_t         hold_q;
  logic          advance_c;
  logic          incoming_mem_c;
  logic          unused_memwb;

  // Pipeline advances on ihit unless a memory op is still outstanding
  assign advance_c      = ihit & ((state != WAIT) | dhit);
  assign incoming_mem_c = ~flush & (idex_dREN | idex_dWEN);

  always_comb begin
    idex_s       = BUBBLE;
    idex_s.rd    = idex_rd;
    idex_s.regW  = idex_regW;
    idex_s.op    = opcode_t'(idex_op);
    idex_s.dREN  = idex_dREN;
    idex_s.dWEN  = idex_dWEN;
    idex_s.data  = idex_result;
    idex_s.store = idex_store;
  end

  // Writeback source: live load data in WAIT, held data once DONE
  always_comb begin
    memwb_d      = BUBBLE;
    memwb_d.rd   = exmem_q.rd;
    memwb_d.regW = exmem_q.regW;
    memwb_d.op   = exmem_q.op;
    memwb_d.data = exmem_q.data;
    if (exmem_q.dREN) begin
      memwb_d.data = (state == DONE) ? hold_q : dmem_rdata;
    end
  end

  dest_stage_reg u_exmem (
    .CLK          (CLK),
    .nRST         (nRST),
    .en           (advance_c),
    .bubble       (flush),
    .zero_rd_supp (1'b1),
    .d            (idex_s),
    .q            (exmem_q)
  );

  dest_stage_reg u_memwb (
    .CLK          (CLK),
    .nRST         (nRST),
    .en           (advance_c),
    .bubble       (1'b0),
    .zero_rd_supp (1'b1),
    .d            (memwb_d),
    .q            (memwb_q)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= state_n;
    end
  end

  // FSM next-state
  always_comb begin
    state_n = state;
    if (advance_c) begin
      state_n = incoming_mem_c ? WAIT : RUN;
    end else if ((state == WAIT) && dhit) begin
      state_n = DONE;
    end
  end

  // Capture load data when memory completes before the pipe can move
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hold_q <= '0;
    end else if ((state == WAIT) && dhit && !ihit) begin
      hold_q <= dmem_rdata;
    end
  end

`ifdef DEST_TRACK_STALL_CNT_EN
  // Saturating stall counter
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cycles <= '0;
    end else if (mem_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

  assign mem_stall   = ~advance_c;
  assign dREN        = (state == WAIT) & exmem_q.dREN;
  assign dWEN        = (state == WAIT) & exmem_q.dWEN;
  assign daddr       = exmem_q.data;
  assign dstore      = exmem_q.store;
  assign exmem_rd    = exmem_q.rd;
  assign exmem_regW  = exmem_q.regW;
  assign exmem_op    = exmem_q.op;
  assign exmem_data  = exmem_q.data;
  assign memwb_rd    = memwb_q.rd;
  assign memwb_regW  = memwb_q.regW;
  assign memwb_op    = memwb_q.op;
  assign memwb_wdata = memwb_q.data;

  assign unused_memwb = ^{memwb_q.dREN, memwb_q.dWEN, memwb_q.store};

endmodule

// File: tb/tb_dest_track_pipe.sv
// Randomized scoreboard bench for dest_track_pipe. A driver issues random
// ID/EX traffic, models the pipeline as "instruction in EX/MEM plus a
// completed-memory flag", and pushes each instruction leaving EX/MEM into a
// queue; a monitor pops and compares MEM/WB whenever the DUT advances.
module tb_dest_track_pipe;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam int         N_CYC    = 4000;

  typedef struct {
    logic [4:0]  rd;
    logic        regW;
    logic [5:0]  op;
    logic        ld;
    logic        st;
    logic [31:0] data;
    logic [31:0] store;
  } instr_t;

  typedef struct {
    logic [4:0]  rd;
    logic        regW;
    logic [5:0]  op;
    logic [31:0] wdata;
  } wb_t;

  logic        CLK = 1'b0;
  logic        nRST, ihit, dhit, flush;
  logic [4:0]  idex_rd;
  logic        idex_regW, idex_dREN, idex_dWEN;
  logic [5:0]  idex_op;
  logic [31:0] idex_result, idex_store, dmem_rdata;
  logic        dREN, dWEN, exmem_regW, memwb_regW, mem_stall;
  logic [31:0] daddr, dstore, exmem_data, memwb_wdata;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [5:0]  exmem_op, memwb_op;
`ifdef DEST_TRACK_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  always #5 CLK = ~CLK;

  dest_track_pipe dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .dhit        (dhit),
    .flush       (flush),
    .idex_rd     (idex_rd),
    .idex_regW   (idex_regW),
    .idex_op     (idex_op),
    .idex_dREN   (idex_dREN),
    .idex_dWEN   (idex_dWEN),
    .idex_result (idex_result),
    .idex_store  (idex_store),
    .dmem_rdata  (dmem_rdata),
    .dREN        (dREN),
    .dWEN        (dWEN),
    .daddr       (daddr),
    .dstore      (dstore),
    .exmem_rd    (exmem_rd),
    .exmem_regW  (exmem_regW),
    .exmem_op    (exmem_op),
    .exmem_data  (exmem_data),
    .memwb_rd    (memwb_rd),
    .memwb_regW  (memwb_regW),
    .memwb_op    (memwb_op),
    .memwb_wdata (memwb_wdata),
`ifdef DEST_TRACK_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .mem_stall   (mem_stall)
  );

  int  n_chk  = 0;
  int  n_fail = 0;
  wb_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    int     kind;
    kind    = $urandom_range(0, 3);
    i.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    i.data  = $urandom;
    i.store = $urandom;
    i.ld    = (kind == 0);
    i.st    = (kind == 1);
    case (kind)
      0:       begin i.op = OP_LW;    i.regW = 1'b1; end
      1:       begin i.op = OP_SW;    i.regW = 1'b0; end
      2:       begin i.op = OP_RTYPE; i.regW = ($urandom_range(0, 5) != 0); end
      default: begin i.op = OP_ADDIU; i.regW = 1'b1; end
    endcase
    return i;
  endfunction

  // Monitor: whenever the DUT signalled an advance, MEM/WB must show the
  // next instruction the model retired from EX/MEM
  bit pend = 1'b0;
  always @(negedge CLK) begin
    wb_t e;
    if (pend) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow: got advance expected none at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("memwb_rd",    32'(memwb_rd),   32'(e.rd));
        chk("memwb_regW",  32'(memwb_regW), 32'(e.regW));
        chk("memwb_op",    32'(memwb_op),   32'(e.op));
        chk("memwb_wdata", memwb_wdata,     e.wdata);
      end
    end
    pend = nRST && !mem_stall;
  end

  // Driver + reference model
  initial begin
    instr_t      m_ex, nx;
    logic        m_done, m_mem, exp_adv, rst, prev_rst;
    logic [31:0] m_held, m_cnt;
    wb_t         w;

    m_ex     = '{default: '0};
    m_done   = 1'b0;
    m_held   = '0;
    m_cnt    = '0;
    prev_rst = 1'b0;
    nRST = 1'b0; ihit = 1'b1; dhit = 1'b0; flush = 1'b0;
    idex_rd = '0; idex_regW = 1'b0; idex_op = '0; idex_dREN = 1'b0; idex_dWEN = 1'b0;
    idex_result = '0; idex_store = '0; dmem_rdata = '0;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge CLK);
      #2;
      // Registered EX/MEM state after the edge
      chk("exmem_rd",   32'(exmem_rd),   32'(m_ex.rd));
      chk("exmem_regW", 32'(exmem_regW), 32'(m_ex.regW));
      chk("exmem_op",   32'(exmem_op),   32'(m_ex.op));
      chk("exmem_data", exmem_data,      m_ex.data);
      if (prev_rst) begin
        chk("rst_memwb_rd",    32'(memwb_rd),   32'd0);
        chk("rst_memwb_regW",  32'(memwb_regW), 32'd0);
        chk("rst_memwb_op",    32'(memwb_op),   32'd0);
        chk("rst_memwb_wdata", memwb_wdata,     32'd0);
        chk("rst_dstore",      dstore,          32'd0);
      end
`ifdef DEST_TRACK_STALL_CNT_EN
      chk("stall_cycles", stall_cycles, m_cnt);
`endif

      // New stimulus
      rst         = (cyc < 2) || ($urandom_range(0, 399) == 0);
      nRST        = !rst;
      ihit        = ($urandom_range(0, 9) < 7);
      dhit        = ($urandom_range(0, 9) < 4);
      flush       = ($urandom_range(0, 9) == 0);
      dmem_rdata  = $urandom;
      nx          = rand_instr();
      idex_rd     = nx.rd;
      idex_regW   = nx.regW;
      idex_op     = nx.op;
      idex_dREN   = nx.ld;
      idex_dWEN   = nx.st;
      idex_result = nx.data;
      idex_store  = nx.store;
      #1;

      // A memory op is outstanding until its dhit has been seen
      m_mem   = m_ex.ld || m_ex.st;
      exp_adv = ihit && (!m_mem || m_done || dhit);
      chk("dREN",      32'(dREN),      32'(m_ex.ld && !m_done));
      chk("dWEN",      32'(dWEN),      32'(m_ex.st && !m_done));
      chk("daddr",     daddr,          m_ex.data);
      chk("dstore",    dstore,         m_ex.store);
      chk("mem_stall", 32'(mem_stall), 32'(!exp_adv));

      // Model effect of the coming edge
      if (rst) begin
        m_ex   = '{default: '0};
        m_done = 1'b0;
        m_cnt  = '0;
      end else begin
        if (!exp_adv && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
        if (exp_adv) begin
          w.rd    = m_ex.rd;
          w.regW  = m_ex.regW;
          w.op    = m_ex.op;
          w.wdata = m_ex.ld ? (m_done ? m_held : dmem_rdata) : m_ex.data;
          sb.push_back(w);
          if (flush) begin
            m_ex = '{default: '0};
          end else begin
            m_ex = nx;
            if (m_ex.rd == 5'd0) m_ex.regW = 1'b0;
          end
          m_done = 1'b0;
        end else if (m_mem && !m_done && dhit) begin
          m_done = 1'b1;
          m_held = dmem_rdata;
        end
      end
      prev_rst = rst;
    end

    // Drain: let the monitor consume the final retirement, then stop
    @(posedge CLK);
    #2;
    nRST = 1'b0;
    @(posedge CLK);
    #2;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
